// File: rtl/qkd_key_packer_master_pkg.sv
// Shared types and constants for the QKD key packer.
package qkd_packer_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 7;
  localparam logic [7:0] MAX_WORDS = 8'd128;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // A requested count of 0, or one larger than the memory, means "fill the memory".
  function automatic logic [7:0] eff_count(input logic [7:0] req);
    return (req == 8'd0 || req > MAX_WORDS) ? MAX_WORDS : req;
  endfunction

endpackage

// File: rtl/qkd_key_packer_master_if.sv
// Avalon-MM write bus between the key packer and the key memory write port.
interface qkd_key_packer_master_if
  import qkd_packer_pkg::*;
();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [WORD_W-1:0] avm_writedata;
  logic [1:0]        avm_byteenable;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_writedata,
    output avm_byteenable
  );

  modport slave (
    input avm_address,
    input avm_chipselect,
    input avm_write,
    input avm_writedata,
    input avm_byteenable
  );

endinterface

// File: rtl/qkd_key_packer_master_crc16.sv
// qkd_crc16_word: one CRC-16-CCITT step over a full 16-bit word, MSB first.
// Only present when QKD_PACKER_CRC_EN is defined.
`ifdef QKD_PACKER_CRC_EN
module qkd_crc16_word
  import qkd_packer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Sixteen serial LFSR steps unrolled into one combinational update.
  always_comb begin
    c = crc_in;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule
`endif

// File: rtl/qkd_key_packer_master.sv
// qkd_key_packer_master: packs the serial sifted-key stream LSB-first into
// 16-bit words and writes them into the key memory starting at base_addr.
// Optional feature macro: QKD_PACKER_CRC_EN adds key_crc over written words.
module qkd_key_packer_master
  import qkd_packer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [7:0]             word_count,
  input  logic                   bit_valid,
  input  logic                   bit_data,
  input  logic                   flush,
  qkd_key_packer_master_if.master avm,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             words_written,
  output logic                   overflow
`ifdef QKD_PACKER_CRC_EN
  ,
  output logic [15:0]            key_crc
`endif
);

  state_t            state, state_nxt;

  logic [WORD_W-1:0] shreg;
  logic [3:0]        bitcnt;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        limit_q;

  logic              wr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [1:0]        be_q;

  logic              take_bit;
  logic              word_full;
  logic              last_word;
  logic              do_flush;
  logic              partial_wr;
  logic              issue_wr;
  logic [4:0]        pend_cnt;
  logic [WORD_W-1:0] cur_word;

  // Decode of the current bit/flush against the word being assembled.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
    take_bit = (state == ST_CAPTURE) && bit_valid;
    cur_word = shreg;
    if (take_bit) cur_word[bitcnt] = bit_data;
    pend_cnt  = {1'b0, bitcnt} + {4'd0, take_bit};
    word_full = take_bit && (bitcnt == 4'd15);
    // Writes are at least 16 cycles apart, so words_written already counts every earlier word here.
    last_word  = word_full && (({1'b0, words_written} + 9'd1) >= {1'b0, limit_q});
    do_flush   = (state == ST_CAPTURE) && flush;
    partial_wr = do_flush && !word_full && (pend_cnt != 5'd0);
    issue_wr   = word_full || partial_wr;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (last_word || do_flush) state_nxt = ST_DRAIN;
      // The pending write was launched on entry and occupies exactly this one cycle.
      ST_DRAIN:   state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, session parameters, write holding register and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg         <= '0;
      bitcnt        <= '0;
      base_q        <= '0;
      limit_q       <= '0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      be_q          <= '0;
      words_written <= '0;
      overflow      <= 1'b0;
    end else begin
      wr_q <= issue_wr;
      if (issue_wr) begin
        wdata_q <= cur_word;
        be_q    <= (pend_cnt > 5'd8) ? 2'b11 : 2'b01;
      end

      if (state == ST_IDLE && start) begin
        shreg         <= '0;
        bitcnt        <= '0;
        words_written <= '0;
        overflow      <= 1'b0;
        base_q        <= base_addr;
        limit_q       <= eff_count(word_count);
      end else begin
        if (take_bit) begin
          if (word_full) begin
            // Clearing here leaves the unfilled bits of a later partial word at 0.
            shreg  <= '0;
            bitcnt <= '0;
          end else begin
            shreg  <= cur_word;
            bitcnt <= bitcnt + 4'd1;
          end
        end
        if (bit_valid && state != ST_CAPTURE) overflow <= 1'b1;
        if (wr_q && words_written != MAX_WORDS) words_written <= words_written + 8'd1;
      end
    end
  end

  assign avm.avm_write      = wr_q;
  assign avm.avm_chipselect = wr_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_byteenable = be_q;
  // words_written only advances at the end of the write cycle, so the sum is this write's slot.
  assign avm.avm_address    = base_q + words_written[ADDR_W-1:0];

`ifdef QKD_PACKER_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_nxt;
  logic [15:0] crc_data;

  assign crc_data = {wdata_q[15:8] & {8{be_q[1]}}, wdata_q[7:0] & {8{be_q[0]}}};

  qkd_crc16_word u_crc (
    .crc_in  (crc_q),
    .data    (crc_data),
    .crc_out (crc_nxt)
  );

  // Running CRC over every word as it is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    crc_q <= CRC_INIT;
    else if (state == ST_IDLE && start) crc_q <= CRC_INIT;
    else if (wr_q)                   crc_q <= crc_nxt;
  end

  assign key_crc = crc_q;
`endif

endmodule
